irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Interrupt request controller feeding the 2-bit interrupt-select input of the CPU datapath's PC vector mux: code 01 selects vector 0x384, code 10 selects vector 0x3E9, code 00 means no interrupt. The block synchronizes and edge-detects two external request lines and latches them as pending flags. It arbitrates by fixed priority and holds the selected code until the control unit acknowledges. It then blocks further requests until return-from-interrupt.

## Interface
- SYNC_STAGES, 2, synchronizer depth per request line (≥2); used only with IRQ_SYNC_EN.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq_in  in  2  external request lines, rising-edge sensitive; bit0 → code 01, bit1 → code 10.
- int_ack  in  1  one-cycle pulse from control unit in the cycle the PC loads the vector.
- int_ret  in  1  one-cycle pulse when return-from-interrupt executes.
- mask_we  in  1  mask register write strobe.
- mask_d  in  2  new mask value; bit=1 enables that line.
- s_interrupcion  out  2  registered vector select to datapath (00/01/10; 11 never driven).
- irq_pending  out  2  registered pending flags.
- in_service  out  1  high while state is SERVICE.

## Operation
- Edge detect: edge[i] = sync[i] & ~prev[i]. prev is updated every cycle. Level-held lines produce a single edge.
- Pending: pending_next = (pending & ~clr) | edge. Set wins over clear on the same line in the same cycle. Masked lines still latch pending.
- Mask: reset value 2'b11. Written on mask_we. Takes effect on the next arbitration.
- Priority: line 0 over line 1. sel = lowest-index bit of (pending & mask).
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if (pending & mask) ≠ 0 → REQ. The cycle of that transition latches sel; s_interrupcion = code(sel) from the next cycle.
  - REQ: s_interrupcion holds code(sel). Mask writes and new higher-priority edges do not change or withdraw it. On int_ack: clr[sel]=1, → SERVICE, s_interrupcion = 00 next cycle.
  - SERVICE: no nesting and no request output. Edges keep latching pending. On int_ret → IDLE.
- int_ack outside REQ is ignored. int_ret outside SERVICE is ignored. int_ack and int_ret asserted together in REQ: only the ack is taken.
- Reset (any time, including mid-REQ/SERVICE) sets:
  - state IDLE;
  - s_interrupcion 00;
  - irq_pending 00;
  - in_service 0;
  - mask 11;
  - synchronizer and prev flops 0.
- A line that is high across reset release yields exactly one edge.

## Timing
- Let N be the first clk edge sampling irq_in[i] high, with the FSM in IDLE and line i enabled.
- With IRQ_SYNC_EN (SYNC_STAGES=2): pending[i] is set at N+2; s_interrupcion is nonzero after N+3.
- Without IRQ_SYNC_EN: pending[i] is set at N; s_interrupcion is nonzero after N+1.
- int_ack at edge A: s_interrupcion = 00, pending[sel] = 0 and in_service = 1 after A.
- int_ret at edge R: in_service = 0 after R. If work is still pending, s_interrupcion is nonzero again after R+1.
- Minimum spacing between accepted edges on one line: 2 cycles (low for ≥1 sampled cycle).

## Configuration
- IRQ_SYNC_EN defined: each irq_in bit passes through SYNC_STAGES reset-to-0 flops before edge detection. Use this for asynchronous sources.
- IRQ_SYNC_EN undefined: irq_in is sampled directly by the edge detector, which removes SYNC_STAGES cycles of latency. Sources must then be synchronous to clk. SYNC_STAGES is ignored.

## Structure
- Package irq_pkg holds:
  - state enum (IDLE, REQ, SERVICE);
  - code constants IRQ_NONE=2'b00, IRQ_V0=2'b01, IRQ_V1=2'b10;
  - vector constants VEC0=10'h384, VEC1=10'h3E9, for bench cross-checking.
- Sub-module irq_edge holds the optional synchronizer plus the prev flop and outputs a one-cycle edge pulse. It is instantiated once per line.
- Pending, mask, arbitration and the FSM live in irq_ctrl.

## Test plan
- Reset, then pulse irq_in[0] high for 1 sampled cycle (sync on) → pending=01 at N+2, s_interrupcion=01 after N+3; int_ack → 00, in_service=1; int_ret → in_service=0, no re-request.
- irq_in=11 rising together → s_interrupcion=01 first. After ack and ret, s_interrupcion=10 one cycle after ret.
- In SERVICE, new edge on line 0 → pending=01, s_interrupcion stays 00 until int_ret, then 01.
- mask_d=10 written, edge on line 0 → pending=01, no request; later write mask_d=11 → s_interrupcion=01.
- Edge on line 0 in the same cycle as its int_ack → pending[0] stays 1, and it is requested again after int_ret.
- Assert reset while in REQ with code 10 → all outputs 00/0 immediately, mask=11, no request after release while irq_in is low.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt request controller.
// IRQ_SYNC_EN selects the input synchronizer build.
package irq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } irq_state_e;

   localparam logic [1:0] IRQ_NONE = 2'b00;
   localparam logic [1:0] IRQ_V0   = 2'b01;
   localparam logic [1:0] IRQ_V1   = 2'b10;

   localparam logic [9:0] VEC0 = 10'h384;
   localparam logic [9:0] VEC1 = 10'h3E9;

   // Line 0 beats line 1; the code doubles as the one-hot line mask.
   function automatic logic [1:0] irq_pick(input logic [1:0] req);
      logic [1:0] code;
      code = IRQ_NONE;
      if (req[0])
         code = IRQ_V0;
      else if (req[1])
         code = IRQ_V1;
      return code;
   endfunction

   function automatic logic [9:0] irq_vec(input logic [1:0] code);
      logic [9:0] vec;
      vec = '0;
      if (code == IRQ_V0)
         vec = VEC0;
      else if (code == IRQ_V1)
         vec = VEC1;
      return vec;
   endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Request/ack/mask bundle between the CPU control path and irq_ctrl.
// IRQ_SYNC_EN does not change this interface.
interface irq_ctrl_if;

   logic [1:0] irq_in;
   logic       int_ack;
   logic       int_ret;
   logic       mask_we;
   logic [1:0] mask_d;
   logic [1:0] s_interrupcion;
   logic [1:0] irq_pending;
   logic       in_service;

   modport master (
      output irq_in,
      output int_ack,
      output int_ret,
      output mask_we,
      output mask_d,
      input  s_interrupcion,
      input  irq_pending,
      input  in_service
   );

   modport slave (
      input  irq_in,
      input  int_ack,
      input  int_ret,
      input  mask_we,
      input  mask_d,
      output s_interrupcion,
      output irq_pending,
      output in_service
   );

endinterface

// File: rtl/irq_ctrl_edge.sv
// Per-line rising-edge detector, with a SYNC_STAGES-deep synchronizer
// in front of it when IRQ_SYNC_EN is defined.
module irq_edge
`ifdef IRQ_SYNC_EN
   #(parameter int SYNC_STAGES = 2)
`endif
   (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic edge_o
);

   logic line;
   logic prev_q;

`ifdef IRQ_SYNC_EN
   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         sync_q <= '0;
      else
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
   end

   assign line = sync_q[SYNC_STAGES-1];
`else
   assign line = d_i;
`endif

   // prev clears on reset so a line already high yields one edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         prev_q <= 1'b0;
      else
         prev_q <= line;
   end

   assign edge_o = line & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Two-line interrupt controller driving the PC vector-select code.
// IRQ_SYNC_EN adds input synchronizers (depth SYNC_STAGES).
module irq_ctrl
   import irq_pkg::*;
`ifdef IRQ_SYNC_EN
   #(parameter int SYNC_STAGES = 2)
`endif
   (
   input  logic      clk,
   input  logic      reset,
   irq_ctrl_if.slave bus
);

   logic [1:0] edge_w;

   for (genvar i = 0; i < 2; i++) begin : g_line
`ifdef IRQ_SYNC_EN
      irq_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
         .clk    (clk),
         .reset  (reset),
         .d_i    (bus.irq_in[i]),
         .edge_o (edge_w[i])
      );
`else
      irq_edge u_edge (
         .clk    (clk),
         .reset  (reset),
         .d_i    (bus.irq_in[i]),
         .edge_o (edge_w[i])
      );
`endif
   end

   irq_state_e state_q, state_d;
   logic [1:0] pend_q, pend_d;
   logic [1:0] en_q, en_d;
   logic [1:0] sint_q, sint_d;
   logic [1:0] clr;
   logic [1:0] act;

   assign act = pend_q & en_q;

   always_comb begin
      state_d = state_q;
      sint_d  = sint_q;
      clr     = 2'b00;
      unique case (state_q)
         IDLE: begin
            if (act != 2'b00) begin
               state_d = REQ;
               sint_d  = irq_pick(act);
            end
         end
         REQ: begin
            // The held code is one-hot on the line being served.
            if (bus.int_ack) begin
               clr     = sint_q;
               state_d = SERVICE;
               sint_d  = IRQ_NONE;
            end
         end
         SERVICE: begin
            if (bus.int_ret)
               state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            sint_d  = IRQ_NONE;
         end
      endcase
   end

   assign pend_d = (pend_q & ~clr) | edge_w;
   assign en_d   = bus.mask_we ? bus.mask_d : en_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pend_q  <= 2'b00;
         en_q    <= 2'b11;
         sint_q  <= IRQ_NONE;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         en_q    <= en_d;
         sint_q  <= sint_d;
      end
   end

   assign bus.s_interrupcion = sint_q;
   assign bus.irq_pending    = pend_q;
   assign bus.in_service     = (state_q == SERVICE);

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: vector table, corner sequences, random vs model.
// Latency follows IRQ_SYNC_EN.
module tb_irq_ctrl;
   import irq_pkg::*;

`ifdef IRQ_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   irq_ctrl_if bus ();

`ifdef IRQ_SYNC_EN
   irq_ctrl #(.SYNC_STAGES(2)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );
`else
   irq_ctrl dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] irq;
      logic       ack;
      logic       ret;
      logic       we;
      logic [1:0] msk;
      logic       dly;
      logic [1:0] s;
      logic [1:0] p;
      logic       svc;
   } vec_t;

   vec_t tbl[$];

   int         m_mode;
   logic [1:0] m_pend;
   logic [1:0] m_mask;
   logic [1:0] m_s;
   logic [1:0] hist[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] irq, input logic ack,
                        input logic ret, input logic we,
                        input logic [1:0] msk);
      bus.irq_in  = irq;
      bus.int_ack = ack;
      bus.int_ret = ret;
      bus.mask_we = we;
      bus.mask_d  = msk;
   endtask

   task automatic chk(input string nm, input logic [1:0] s,
                      input logic [1:0] p, input logic svc);
      vectors++;
      if (bus.s_interrupcion !== s || bus.irq_pending !== p ||
          bus.in_service !== svc) begin
         miscompares++;
         $display("FAIL %s: got s=%b p=%b svc=%b, want s=%b p=%b svc=%b",
                  nm, bus.s_interrupcion, bus.irq_pending, bus.in_service,
                  s, p, svc);
      end
   endtask

   task automatic add(input logic [1:0] irq, input logic ack,
                      input logic ret, input logic we,
                      input logic [1:0] msk, input logic dly,
                      input logic [1:0] s, input logic [1:0] p,
                      input logic svc);
      tbl.push_back('{irq, ack, ret, we, msk, dly, s, p, svc});
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_pend = 2'b00;
      m_mask = 2'b11;
      m_s    = 2'b00;
      hist.delete();
      for (int i = 0; i <= LAT; i++)
         hist.push_back(2'b00);
   endtask

   // One clock of the spec's rules; hist[j] is irq_in from j+1 edges ago.
   task automatic model_step(input logic [1:0] irq, input logic ack,
                             input logic ret, input logic we,
                             input logic [1:0] msk);
      logic [1:0] seen, prv, e, act, clr;
      seen = (LAT == 0) ? irq : hist[LAT-1];
      prv  = hist[LAT];
      e    = seen & ~prv;
      act  = m_pend & m_mask;
      clr  = 2'b00;
      if (m_mode == 0) begin
         if (act != 2'b00) begin
            m_mode = 1;
            m_s = act[0] ? 2'b01 : 2'b10;
         end
      end else if (m_mode == 1) begin
         if (ack) begin
            clr[(m_s == 2'b01) ? 0 : 1] = 1'b1;
            m_s = 2'b00;
            m_mode = 2;
         end
      end else if (ret) begin
         m_mode = 0;
      end
      m_pend = (m_pend & ~clr) | e;
      if (we)
         m_mask = msk;
      hist.push_front(irq);
      void'(hist.pop_back());
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      drive(2'b00, 0, 0, 0, 2'b00);
      repeat (3) step();
      chk("reset_state", 2'b00, 2'b00, 1'b0);
      rst_n = 1'b1;
      step();

      // pulse line 0, ack, ret
      add(2'b01, 0, 0, 0, 2'b00, 1, 2'b00, 2'b01, 0);
      add(2'b00, 0, 0, 0, 2'b00, 0, 2'b01, 2'b01, 0);
      add(2'b00, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1);
      add(2'b00, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0);
      add(2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0);
      // both lines together; ack+ret, stray ret/ack
      add(2'b11, 0, 0, 0, 2'b00, 1, 2'b00, 2'b11, 0);
      add(2'b00, 0, 0, 0, 2'b00, 0, 2'b01, 2'b11, 0);
      add(2'b00, 1, 1, 0, 2'b00, 0, 2'b00, 2'b10, 1);
      add(2'b00, 0, 1, 0, 2'b00, 0, 2'b00, 2'b10, 0);
      add(2'b00, 0, 0, 0, 2'b00, 0, 2'b10, 2'b10, 0);
      add(2'b00, 0, 1, 0, 2'b00, 0, 2'b10, 2'b10, 0);
      add(2'b00, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1);
      add(2'b00, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1);
      add(2'b00, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0);
      // edge while in SERVICE
      add(2'b01, 0, 0, 0, 2'b00, 1, 2'b00, 2'b01, 0);
      add(2'b00, 0, 0, 0, 2'b00, 0, 2'b01, 2'b01, 0);
      add(2'b00, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1);
      add(2'b01, 0, 0, 0, 2'b00, 1, 2'b00, 2'b01, 1);
      add(2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 1);
      add(2'b00, 0, 1, 0, 2'b00, 0, 2'b00, 2'b01, 0);
      add(2'b00, 0, 0, 0, 2'b00, 0, 2'b01, 2'b01, 0);
      add(2'b00, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1);
      add(2'b00, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0);
      // masked line still latches, released by mask write
      add(2'b00, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0);
      add(2'b01, 0, 0, 0, 2'b00, 1, 2'b00, 2'b01, 0);
      add(2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 0);
      add(2'b00, 0, 0, 1, 2'b11, 0, 2'b00, 2'b01, 0);
      add(2'b00, 0, 0, 0, 2'b00, 0, 2'b01, 2'b01, 0);
      add(2'b00, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1);
      add(2'b00, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].irq, tbl[i].ack, tbl[i].ret, tbl[i].we, tbl[i].msk);
         step();
         if (tbl[i].dly) begin
            drive(tbl[i].irq, 0, 0, 0, 2'b00);
            repeat (LAT) step();
         end
         chk($sformatf("tbl[%0d]", i), tbl[i].s, tbl[i].p, tbl[i].svc);
      end
      drive(2'b00, 0, 0, 0, 2'b00);
      step();

      // edge on line 0 lands in the same cycle as its ack
      drive(2'b01, 0, 0, 0, 2'b00);
      step();
      repeat (LAT) step();
      drive(2'b00, 0, 0, 0, 2'b00);
      step();
      chk("ackedge_req", 2'b01, 2'b01, 1'b0);
      drive(2'b01, 0, 0, 0, 2'b00);
      repeat (LAT) step();
      drive(2'b01, 1, 0, 0, 2'b00);
      step();
      drive(2'b00, 0, 0, 0, 2'b00);
      chk("ackedge_ack", 2'b00, 2'b01, 1'b1);
      drive(2'b00, 0, 1, 0, 2'b00);
      step();
      chk("ackedge_ret", 2'b00, 2'b01, 1'b0);
      drive(2'b00, 0, 0, 0, 2'b00);
      step();
      chk("ackedge_rereq", 2'b01, 2'b01, 1'b0);
      vectors++;
      if (irq_vec(bus.s_interrupcion) !== 10'h384) begin
         miscompares++;
         $display("FAIL vec0: got %h want 384", irq_vec(bus.s_interrupcion));
      end
      drive(2'b00, 1, 0, 0, 2'b00);
      step();
      drive(2'b00, 0, 1, 0, 2'b00);
      step();
      drive(2'b00, 0, 0, 0, 2'b00);
      chk("ackedge_done", 2'b00, 2'b00, 1'b0);

      // reset in REQ with code 10, after masking everything
      drive(2'b10, 0, 0, 0, 2'b00);
      step();
      repeat (LAT) step();
      drive(2'b00, 0, 0, 0, 2'b00);
      step();
      chk("req10", 2'b10, 2'b10, 1'b0);
      drive(2'b00, 0, 0, 1, 2'b00);
      step();
      drive(2'b00, 0, 0, 0, 2'b00);
      chk("req10_hold", 2'b10, 2'b10, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset", 2'b00, 2'b00, 1'b0);
      step();
      step();
      rst_n = 1'b1;
      repeat (4) step();
      chk("post_reset_quiet", 2'b00, 2'b00, 1'b0);
      drive(2'b01, 0, 0, 0, 2'b00);
      step();
      repeat (LAT) step();
      drive(2'b00, 0, 0, 0, 2'b00);
      chk("post_reset_pend", 2'b00, 2'b01, 1'b0);
      step();
      chk("mask_reset_11", 2'b01, 2'b01, 1'b0);
      drive(2'b00, 1, 0, 0, 2'b00);
      step();
      drive(2'b00, 0, 1, 0, 2'b00);
      step();
      drive(2'b00, 0, 0, 0, 2'b00);

      // line held high across reset release gives one edge
      rst_n = 1'b0;
      drive(2'b01, 0, 0, 0, 2'b00);
      step();
      rst_n = 1'b1;
      step();
      repeat (LAT) step();
      chk("hold_rel_pend", 2'b00, 2'b01, 1'b0);
      step();
      chk("hold_rel_req", 2'b01, 2'b01, 1'b0);
      drive(2'b01, 1, 0, 0, 2'b00);
      step();
      drive(2'b01, 0, 1, 0, 2'b00);
      step();
      drive(2'b01, 0, 0, 0, 2'b00);
      repeat (LAT + 3) step();
      chk("hold_rel_single", 2'b00, 2'b00, 1'b0);

      // random stimulus against the reference model
      drive(2'b00, 0, 0, 0, 2'b00);
      rst_n = 1'b0;
      step();
      model_reset();
      rst_n = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         logic [1:0] ri, rm;
         logic ra, rr, rw;
         ri = 2'($urandom_range(0, 3));
         ra = ($urandom_range(0, 3) == 0);
         rr = ($urandom_range(0, 3) == 0);
         rw = ($urandom_range(0, 7) == 0);
         rm = 2'($urandom_range(0, 3));
         drive(ri, ra, rr, rw, rm);
         model_step(ri, ra, rr, rw, rm);
         step();
         chk($sformatf("rand[%0d]", c), m_s, m_pend, (m_mode == 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
